alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit combinational ALU.
- Generalises operand width, widens the op select to 3 bits, and adds multi-bit shifts, an unsigned multiply and a signed-overflow flag.
- Single-cycle ops finish in 1 cycle; shifts and multiply iterate one step per cycle behind a start/busy/done handshake.
- Sits between the register file and the writeback stage of the datapath; results and flags are registered and held until the next completion.

---
 rtl/alu_seq.sv | 217 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle parametrised ALU with start/busy/done handshake
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zout,
  output logic             vout
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         sel_q, sel_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               zout_q, zout_d;
  logic               vout_q, vout_d;
  logic               done_q, done_d;

  // Single-cycle arithmetic on the latched operands
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   sub_res;
  logic               add_v, sub_v, sub_c;
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_res  = a_q - b_q;
  assign sub_c    = (a_q < b_q);
  assign add_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != a_q[WIDTH-1]);
  assign sub_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);

  // One shift-add multiply step: the product register holds {high partial, remaining multiplier}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  // One-bit shift steps on the working register; the bit leaving is the candidate carry
  logic [WIDTH-1:0]   shl_next, shr_next;
  assign shl_next = {acc_q[WIDTH-2:0], 1'b0};
  assign shr_next = {1'b0, acc_q[WIDTH-1:1]};

  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c, fin_v;

  // Next-state, operand capture, iteration and completion logic
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    result_d = result_q;
    cout_d   = cout_q;
    zout_d   = zout_q;
    vout_d   = vout_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    fin_res  = '0;
    fin_c    = 1'b0;
    fin_v    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sel_d   = alu_sel;
          acc_d   = a;
          prod_d  = {{WIDTH{1'b0}}, b};
          cnt_d   = (alu_sel == OP_MUL) ? '0 : shamt;
          state_d = RUN;
        end
      end
      RUN: begin
        case (sel_q)
          OP_ADD: begin
            fin     = 1'b1;
            fin_res = add_full[WIDTH-1:0];
            fin_c   = add_full[WIDTH];
            fin_v   = add_v;
          end
          OP_SUB: begin
            fin     = 1'b1;
            fin_res = sub_res;
            fin_c   = sub_c;
            fin_v   = sub_v;
          end
          OP_AND: begin
            fin     = 1'b1;
            fin_res = a_q & b_q;
          end
          OP_OR: begin
            fin     = 1'b1;
            fin_res = a_q | b_q;
          end
          OP_XOR: begin
            fin     = 1'b1;
            fin_res = a_q ^ b_q;
          end
          OP_SHL, OP_SHR: begin
            if (cnt_q == '0) begin
              // Zero shift passes A through with no carry after the minimum one cycle
              fin     = 1'b1;
              fin_res = acc_q;
            end else if (cnt_q == CNT_ONE) begin
              fin     = 1'b1;
              fin_res = (sel_q == OP_SHL) ? shl_next : shr_next;
              fin_c   = (sel_q == OP_SHL) ? acc_q[WIDTH-1] : acc_q[0];
            end else begin
              acc_d = (sel_q == OP_SHL) ? shl_next : shr_next;
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          OP_MUL: begin
            if (cnt_q == CNT_LAST) begin
              fin     = 1'b1;
              fin_res = mul_next[WIDTH-1:0];
              fin_c   = |mul_next[2*WIDTH-1:WIDTH];
            end else begin
              prod_d = mul_next;
              cnt_d  = cnt_q + CNT_ONE;
            end
          end
          default: begin
            fin = 1'b1;
          end
        endcase

        if (fin) begin
          result_d = fin_res;
          cout_d   = fin_c;
          vout_d   = fin_v;
          zout_d   = (fin_res == '0);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, working and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zout_q   <= 1'b0;
      vout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zout_q   <= zout_d;
      vout_q   <= vout_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zout   = zout_q;
  assign vout   = vout_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] alu_sel;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       zout;
  logic       vout;

  int total;
  int bad;

  alu_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .alu_sel (alu_sel),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cout    (cout),
    .zout    (zout),
    .vout    (vout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs after accept, and check latency and outputs
  task automatic run_op(input string tag, input logic [2:0] s, input logic [7:0] av,
                        input logic [7:0] bv, input logic [2:0] sh, input int lat,
                        input logic [7:0] er, input logic ec, input logic ez, input logic ev);
    int n;
    n = 0;
    @(negedge clk);
    alu_sel = s; a = av; b = bv; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~av; b = ~bv; alu_sel = ~s; shamt = ~sh;
    check({tag, ".busy_run"}, 32'(busy), 32'd1);
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".zout"}, 32'(zout), 32'(ez));
    check({tag, ".vout"}, 32'(vout), 32'(ev));
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int ndone;
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_sel = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", {29'd0, cout, zout, vout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //      tag       op      a      b      sh  L  result c     z     v
    run_op("add_ff", 3'b000, 8'hFF, 8'h01, 3'd0, 1, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("add_ov", 3'b000, 8'h7F, 8'h01, 3'd0, 1, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("sub_ov", 3'b001, 8'h80, 8'h01, 3'd0, 1, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op("sub_bw", 3'b001, 8'h01, 8'h02, 3'd0, 1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("and",    3'b010, 8'hF0, 8'h3C, 3'd0, 1, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or",     3'b011, 8'hF0, 8'h0C, 3'd0, 1, 8'hFC, 1'b0, 1'b0, 1'b0);
    run_op("xor",    3'b100, 8'hA5, 8'hA5, 3'd0, 1, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("shl3",   3'b101, 8'h81, 8'h00, 3'd3, 3, 8'h08, 1'b0, 1'b0, 1'b0);
    run_op("shl1",   3'b101, 8'h81, 8'h00, 3'd1, 1, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op("shl0",   3'b101, 8'h81, 8'h00, 3'd0, 1, 8'h81, 1'b0, 1'b0, 1'b0);
    run_op("shr1",   3'b110, 8'h81, 8'h00, 3'd1, 1, 8'h40, 1'b1, 1'b0, 1'b0);
    run_op("shr7",   3'b110, 8'h80, 8'h00, 3'd7, 7, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("mul_10", 3'b111, 8'h10, 8'h10, 3'd0, 8, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("mul_0f", 3'b111, 8'h0F, 8'h0F, 3'd0, 8, 8'hE1, 1'b0, 1'b0, 1'b0);

    // A second start in the middle of a multiply must be dropped
    @(negedge clk);
    alu_sel = 3'b111; a = 8'h0F; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        start = 1'b1; alu_sel = 3'b000; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
    end
    check("mid_start.ndone", 32'(ndone), 32'd1);
    check("mid_start.result", 32'(result), 32'hE1);
    check("mid_start.busy", 32'(busy), 32'd0);

    // Start held through the done cycle is accepted on the following edge
    @(negedge clk);
    alu_sel = 3'b000; a = 8'h03; b = 8'h04; start = 1'b1;
    @(posedge clk);
    #1;
    check("held.busy1", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("held.done1", 32'(done), 32'd1);
    check("held.res1", 32'(result), 32'h07);
    check("held.idle", 32'(busy), 32'd0);
    alu_sel = 3'b001; a = 8'h09; b = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held.busy2", 32'(busy), 32'd1);
    check("held.nodone", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("held.done2", 32'(done), 32'd1);
    check("held.res2", 32'(result), 32'h06);

    // Reset in the middle of a long shift aborts it and clears outputs
    @(negedge clk);
    alu_sel = 3'b101; a = 8'hFF; shamt = 3'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.result", 32'(result), 32'd0);
    check("abort.flags", {29'd0, cout, zout, vout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort.ndone", 32'(ndone), 32'd0);
    run_op("add_post", 3'b000, 8'h05, 8'h03, 3'd0, 1, 8'h08, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
